// File: rtl/ex_stage.sv
// Execute stage: operand bypass muxes, ALU and the EX/MEM pipeline register.
// Define RV_EX_MULDIV_EN to build the 32-step shift-add MUL FSM; otherwise ALUOp 10 yields 0.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      ForwardA_i,
  input  logic [1:0]      ForwardB_i,
  input  logic            ID_EX_valid_i,
  input  logic [XLEN-1:0] ID_EX_RS_data_i,
  input  logic [XLEN-1:0] ID_EX_RT_data_i,
  input  logic [XLEN-1:0] ID_EX_Imm_i,
  input  logic            ID_EX_ALUSrc_i,
  input  logic [3:0]      ID_EX_ALUOp_i,
  input  logic [4:0]      ID_EX_RD_i,
  input  logic            ID_EX_RegWrite_i,
  input  logic            ID_EX_MemRead_i,
  input  logic            ID_EX_MemWrite_i,
  input  logic [XLEN-1:0] MEM_WB_data_i,
  input  logic            flush_i,
  input  logic            mem_stall_i,
  output logic            ex_busy_o,
  output logic [XLEN-1:0] EX_MEM_ALU_result_o,
  output logic [XLEN-1:0] EX_MEM_store_data_o,
  output logic [4:0]      EX_MEM_RD_o,
  output logic            EX_MEM_RegWrite_o,
  output logic            EX_MEM_MemRead_o,
  output logic            EX_MEM_MemWrite_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } ex_mem_t;

  ex_mem_t ex_mem_reg, ex_mem_next, ex_mem_instr;

  logic [XLEN-1:0] op_a, op_b, rs2_fwd, alu_result;
  logic [4:0]      shamt;

  // Operand bypass: index 0 is operand A, index 1 is forwarded rs2.
  logic [1:0]      fwd_sel [2];
  logic [XLEN-1:0] fwd_rf  [2];
  logic [XLEN-1:0] fwd_val [2];

  assign fwd_sel[0] = ForwardA_i;
  assign fwd_sel[1] = ForwardB_i;
  assign fwd_rf[0]  = ID_EX_RS_data_i;
  assign fwd_rf[1]  = ID_EX_RT_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_val[gi] = (fwd_sel[gi] == 2'b10) ? ex_mem_reg.result :
                           (fwd_sel[gi] == 2'b01) ? MEM_WB_data_i : fwd_rf[gi];
    end
  endgenerate

  assign op_a    = fwd_val[0];
  assign rs2_fwd = fwd_val[1];
  assign op_b    = ID_EX_ALUSrc_i ? ID_EX_Imm_i : rs2_fwd;
  assign shamt   = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (ID_EX_ALUOp_i)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLL:  alu_result = op_a << shamt;
      OP_SRL:  alu_result = op_a >> shamt;
      OP_SRA:  alu_result = $signed(op_a) >>> shamt;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    ex_mem_instr          = '0;
    ex_mem_instr.result   = alu_result;
    ex_mem_instr.store    = rs2_fwd;
    ex_mem_instr.rd       = ID_EX_RD_i;
    ex_mem_instr.regwrite = ID_EX_RegWrite_i;
    ex_mem_instr.memread  = ID_EX_MemRead_i;
    ex_mem_instr.memwrite = ID_EX_MemWrite_i;
  end

`ifdef RV_EX_MULDIV_EN
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      count_reg, count_next;
  logic [XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0] mplier_reg, mplier_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] mul_sum;
  ex_mem_t         mul_info_reg, mul_info_next;

  assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  assign ex_busy_o = rst_ni && !flush_i &&
                     ((state_reg == S_IDLE && ID_EX_valid_i && ID_EX_ALUOp_i == OP_MUL) ||
                      (state_reg == S_MUL && count_reg != 5'd31));

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    mcand_next    = mcand_reg;
    mplier_next   = mplier_reg;
    acc_next      = acc_reg;
    mul_info_next = mul_info_reg;
    ex_mem_next   = ex_mem_reg;
    if (flush_i) begin
      ex_mem_next = '0;
      state_next  = S_IDLE;
      count_next  = '0;
    end else if (mem_stall_i) begin
      ex_mem_next = ex_mem_reg;
    end else if (state_reg == S_MUL) begin
      acc_next    = mul_sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      count_next  = count_reg + 5'd1;
      if (count_reg == 5'd31) begin
        ex_mem_next        = mul_info_reg;
        ex_mem_next.result = mul_sum;
        state_next         = S_IDLE;
      end else begin
        ex_mem_next = '0;
      end
    end else if (!ID_EX_valid_i) begin
      ex_mem_next = '0;
    end else if (ID_EX_ALUOp_i == OP_MUL) begin
      // Operands and controls are frozen here; later bypass changes do not matter.
      mcand_next    = op_a;
      mplier_next   = op_b;
      acc_next      = '0;
      count_next    = '0;
      mul_info_next = ex_mem_instr;
      state_next    = S_MUL;
      ex_mem_next   = '0;
    end else begin
      ex_mem_next = ex_mem_instr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      mul_info_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      mcand_reg    <= mcand_next;
      mplier_reg   <= mplier_next;
      acc_reg      <= acc_next;
      mul_info_reg <= mul_info_next;
    end
  end
`else
  assign ex_busy_o = 1'b0;

  always_comb begin
    ex_mem_next = ex_mem_reg;
    if (flush_i) begin
      ex_mem_next = '0;
    end else if (mem_stall_i) begin
      ex_mem_next = ex_mem_reg;
    end else if (!ID_EX_valid_i) begin
      ex_mem_next = '0;
    end else begin
      ex_mem_next = ex_mem_instr;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_mem_reg <= '0;
    end else begin
      ex_mem_reg <= ex_mem_next;
    end
  end

  assign EX_MEM_ALU_result_o = ex_mem_reg.result;
  assign EX_MEM_store_data_o = ex_mem_reg.store;
  assign EX_MEM_RD_o         = ex_mem_reg.rd;
  assign EX_MEM_RegWrite_o   = ex_mem_reg.regwrite;
  assign EX_MEM_MemRead_o    = ex_mem_reg.memread;
  assign EX_MEM_MemWrite_o   = ex_mem_reg.memwrite;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; MUL expectations follow RV_EX_MULDIV_EN.
module tb_ex_stage;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic        clk_i, rst_ni;
  logic [1:0]  ForwardA_i, ForwardB_i;
  logic        ID_EX_valid_i;
  logic [31:0] ID_EX_RS_data_i, ID_EX_RT_data_i, ID_EX_Imm_i;
  logic        ID_EX_ALUSrc_i;
  logic [3:0]  ID_EX_ALUOp_i;
  logic [4:0]  ID_EX_RD_i;
  logic        ID_EX_RegWrite_i, ID_EX_MemRead_i, ID_EX_MemWrite_i;
  logic [31:0] MEM_WB_data_i;
  logic        flush_i, mem_stall_i;
  logic        ex_busy_o;
  logic [31:0] EX_MEM_ALU_result_o, EX_MEM_store_data_o;
  logic [4:0]  EX_MEM_RD_o;
  logic        EX_MEM_RegWrite_o, EX_MEM_MemRead_o, EX_MEM_MemWrite_o;

  int tests_run  = 0;
  int fail_count = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ForwardA_i(ForwardA_i), .ForwardB_i(ForwardB_i),
    .ID_EX_valid_i(ID_EX_valid_i),
    .ID_EX_RS_data_i(ID_EX_RS_data_i), .ID_EX_RT_data_i(ID_EX_RT_data_i),
    .ID_EX_Imm_i(ID_EX_Imm_i), .ID_EX_ALUSrc_i(ID_EX_ALUSrc_i),
    .ID_EX_ALUOp_i(ID_EX_ALUOp_i), .ID_EX_RD_i(ID_EX_RD_i),
    .ID_EX_RegWrite_i(ID_EX_RegWrite_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
    .ID_EX_MemWrite_i(ID_EX_MemWrite_i),
    .MEM_WB_data_i(MEM_WB_data_i), .flush_i(flush_i), .mem_stall_i(mem_stall_i),
    .ex_busy_o(ex_busy_o),
    .EX_MEM_ALU_result_o(EX_MEM_ALU_result_o), .EX_MEM_store_data_o(EX_MEM_store_data_o),
    .EX_MEM_RD_o(EX_MEM_RD_o), .EX_MEM_RegWrite_o(EX_MEM_RegWrite_o),
    .EX_MEM_MemRead_o(EX_MEM_MemRead_o), .EX_MEM_MemWrite_o(EX_MEM_MemWrite_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] %s ok 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic alusrc, input logic [4:0] rd);
    ID_EX_valid_i    = 1'b1;
    ID_EX_ALUOp_i    = op;
    ID_EX_RS_data_i  = rs;
    ID_EX_RT_data_i  = rt;
    ID_EX_Imm_i      = imm;
    ID_EX_ALUSrc_i   = alusrc;
    ID_EX_RD_i       = rd;
    ID_EX_RegWrite_i = 1'b1;
    ID_EX_MemRead_i  = 1'b0;
    ID_EX_MemWrite_i = 1'b0;
    ForwardA_i       = 2'b00;
    ForwardB_i       = 2'b00;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic alusrc,
                         input logic [31:0] exp);
    set_op(op, rs, rt, imm, alusrc, 5'd1);
    tick();
    check(tag, EX_MEM_ALU_result_o, exp);
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    mem_stall_i = 1'b0;
    MEM_WB_data_i = '0;
    set_op(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);

    // Reset held across edges with a valid ADD present.
    tick(); tick();
    check("rst_result", EX_MEM_ALU_result_o, 32'd0);
    check("rst_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd0);
    check("rst_rd", {27'd0, EX_MEM_RD_o}, 32'd0);
    check("rst_store", EX_MEM_store_data_o, 32'd0);
    check("rst_busy", {31'd0, ex_busy_o}, 32'd0);

    rst_ni = 1'b1;
    tick();
    check("add_result", EX_MEM_ALU_result_o, 32'd12);
    check("add_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd1);
    check("add_rd", {27'd0, EX_MEM_RD_o}, 32'd3);
    check("add_store", EX_MEM_store_data_o, 32'd7);

    // Bypass selects.
    run_alu("fwd_prep", OP_ADD, 32'h10, 32'h0, 32'h0, 1'b0, 32'h10);
    set_op(OP_ADD, 32'h99, 32'h0, 32'h1, 1'b1, 5'd2);
    MEM_WB_data_i = 32'h20;
    ForwardA_i = 2'b10;
    tick();
    check("fwdA_exmem", EX_MEM_ALU_result_o, 32'h11);
    ForwardA_i = 2'b01;
    tick();
    check("fwdA_memwb", EX_MEM_ALU_result_o, 32'h21);
    ForwardA_i = 2'b11;
    tick();
    check("fwdA_11", EX_MEM_ALU_result_o, 32'h9A);
    set_op(OP_ADD, 32'h1, 32'h5, 32'h0, 1'b0, 5'd2);
    ForwardB_i = 2'b10;
    tick();
    check("fwdB_result", EX_MEM_ALU_result_o, 32'h9B);
    check("fwdB_store", EX_MEM_store_data_o, 32'h9A);

    // ALU operations.
    run_alu("sub_wrap", OP_SUB, 32'h0, 32'h1, 32'h0, 1'b0, 32'hFFFF_FFFF);
    run_alu("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h1);
    run_alu("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0);
    run_alu("sra_36", OP_SRA, 32'h8000_0000, 32'h0, 32'd36, 1'b1, 32'hF800_0000);
    run_alu("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0, 1'b0, 32'h0800_0000);
    run_alu("sll", OP_SLL, 32'h0000_00F1, 32'd8, 32'h0, 1'b0, 32'h0000_F100);
    run_alu("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0, 32'h00F0_1200);
    run_alu("or", OP_OR, 32'hF000_000F, 32'h0000_F0F0, 32'h0, 1'b0, 32'hF000_F0FF);
    run_alu("xor", OP_XOR, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0, 1'b0, 32'h0F0F_F0F0);
    run_alu("op12_zero", 4'd12, 32'h1234, 32'h5678, 32'h0, 1'b0, 32'h0);

    // Store controls.
    set_op(OP_ADD, 32'h100, 32'hCAFE, 32'h8, 1'b1, 5'd0);
    ID_EX_RegWrite_i = 1'b0;
    ID_EX_MemWrite_i = 1'b1;
    tick();
    check("sw_addr", EX_MEM_ALU_result_o, 32'h108);
    check("sw_store", EX_MEM_store_data_o, 32'hCAFE);
    check("sw_memwrite", {31'd0, EX_MEM_MemWrite_o}, 32'd1);
    check("sw_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd0);

    // Stall, flush and bubble priority.
    run_alu("pre_stall", OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5);
    set_op(OP_ADD, 32'd10, 32'd10, 32'd0, 1'b0, 5'd4);
    mem_stall_i = 1'b1;
    tick();
    check("stall_hold", EX_MEM_ALU_result_o, 32'd5);
    check("stall_hold_rd", {27'd0, EX_MEM_RD_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    check("flush_over_stall", EX_MEM_ALU_result_o, 32'd0);
    check("flush_over_stall_rw", {31'd0, EX_MEM_RegWrite_o}, 32'd0);
    flush_i = 1'b0;
    mem_stall_i = 1'b0;
    tick();
    check("after_stall_add", EX_MEM_ALU_result_o, 32'd20);
    ID_EX_valid_i = 1'b0;
    tick();
    check("invalid_bubble", EX_MEM_ALU_result_o, 32'd0);
    check("invalid_bubble_rw", {31'd0, EX_MEM_RegWrite_o}, 32'd0);

`ifdef RV_EX_MULDIV_EN
    // MUL: busy cycles 0..31, result after E32; bypass changes mid-run are ignored.
    set_op(OP_MUL, 32'h1234_5678, 32'h10, 32'h0, 1'b0, 5'd7);
    #1;
    check("mul_busy_c0", {31'd0, ex_busy_o}, 32'd1);
    tick();
    for (int c = 1; c <= 31; c++) begin
      if (c == 4) begin
        ForwardA_i = 2'b01;
        MEM_WB_data_i = 32'hDEAD_BEEF;
      end
      #1;
      check($sformatf("mul_busy_c%0d", c), {31'd0, ex_busy_o}, 32'd1);
      check($sformatf("mul_bubble_c%0d", c), {31'd0, EX_MEM_RegWrite_o}, 32'd0);
      tick();
    end
    check("mul_busy_c32", {31'd0, ex_busy_o}, 32'd0);
    tick();
    check("mul_result", EX_MEM_ALU_result_o, 32'h2345_6780);
    check("mul_rd", {27'd0, EX_MEM_RD_o}, 32'd7);
    check("mul_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd1);
    check("mul_b2b_busy", {31'd0, ex_busy_o}, 32'd1);
    ID_EX_valid_i = 1'b0;
    ForwardA_i = 2'b00;
    tick();

    // Flush in cycle 10 aborts the multiply.
    set_op(OP_MUL, 32'd6, 32'd7, 32'h0, 1'b0, 5'd9);
    tick();
    repeat (9) tick();
    flush_i = 1'b1;
    #1;
    check("flush_busy_c10", {31'd0, ex_busy_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    ID_EX_valid_i = 1'b0;
    #1;
    check("flush_idle_busy", {31'd0, ex_busy_o}, 32'd0);
    for (int c = 0; c < 30; c++) begin
      check($sformatf("flush_nowrite_%0d", c), EX_MEM_ALU_result_o, 32'd0);
      tick();
    end
    run_alu("post_flush_add", OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 32'd5);

    // mem_stall_i for cycles 10..12 delays the product by three cycles.
    set_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd11);
    tick();
    for (int c = 1; c <= 34; c++) begin
      mem_stall_i = (c >= 10 && c <= 12);
      #1;
      check($sformatf("stall_mul_busy_c%0d", c), {31'd0, ex_busy_o}, 32'd1);
      check($sformatf("stall_mul_bubble_c%0d", c), {31'd0, EX_MEM_RegWrite_o}, 32'd0);
      tick();
    end
    mem_stall_i = 1'b0;
    check("stall_mul_busy_c35", {31'd0, ex_busy_o}, 32'd0);
    tick();
    ID_EX_valid_i = 1'b0;
    check("stall_mul_result", EX_MEM_ALU_result_o, 32'd1);
    check("stall_mul_rd", {27'd0, EX_MEM_RD_o}, 32'd11);

    // Asynchronous reset in the middle of a multiply.
    set_op(OP_MUL, 32'd3, 32'd5, 32'h0, 1'b0, 5'd4);
    tick();
    repeat (5) tick();
    ID_EX_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_mul_busy", {31'd0, ex_busy_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    check("rst_mid_mul_idle", {31'd0, ex_busy_o}, 32'd0);
    tick();
    check("rst_mid_mul_nowrite", {31'd0, EX_MEM_RegWrite_o}, 32'd0);
`else
    // Without the multiplier, MUL is a single-cycle op returning 0.
    set_op(OP_MUL, 32'h1234_5678, 32'h10, 32'h0, 1'b0, 5'd7);
    #1;
    check("mul_off_busy", {31'd0, ex_busy_o}, 32'd0);
    tick();
    check("mul_off_result", EX_MEM_ALU_result_o, 32'd0);
    check("mul_off_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd1);
    check("mul_off_rd", {27'd0, EX_MEM_RD_o}, 32'd7);
`endif

    // Reset clears EX/MEM without a clock edge.
    run_alu("pre_async_rst", OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2);
    rst_ni = 1'b0;
    #1;
    check("async_rst_result", EX_MEM_ALU_result_o, 32'd0);
    check("async_rst_regwrite", {31'd0, EX_MEM_RegWrite_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
